fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the register bank and decode.
- Owns the fetch PC and issues word fetches on a req/ack instruction-memory port.
- Buffers returned instructions in a small FIFO for decode.
- Publishes the architectural R15 value (fetch address + 8) to the register bank's PC write port, and redirects on branches from execute.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, instruction-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until accepted.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  request accepted; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- branch_valid  in  1  single-cycle redirect from execute.
- branch_target  in  32  redirect address; bits [1:0] ignored (treated as 0).
- instr_valid  out  1  buffer head is valid.
- instr  out  32  buffer head instruction.
- instr_pc  out  32  address of the buffer head instruction.
- instr_ready  in  1  decode consumes the head when instr_valid && instr_ready.
- pc_write  out  32  R15 value to the register bank.
- pc_w  out  1  one-cycle write strobe for pc_write.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=IDLE, fetch_pc=RESET_VECTOR, FIFO empty.
  - imem_req=0, imem_addr=RESET_VECTOR.
  - instr_valid=0, instr=0, instr_pc=0.
  - pc_w=0, pc_write=0.
- Reset mid-transaction abandons any outstanding request; the memory must tolerate a dropped req.
- A transfer completes in a cycle where imem_req && imem_ack.
- At most one request is outstanding.
- The unit never deasserts imem_req or changes imem_addr before the ack arrives.
- States:
  - IDLE: no request outstanding. If count < DEPTH, go to BUSY, drive imem_req=1 and imem_addr=fetch_pc.
  - BUSY: request outstanding. On ack with no branch in the same cycle:
    - push {imem_rdata, imem_addr} into the FIFO.
    - fetch_pc <= imem_addr+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - pc_w=1 and pc_write=imem_addr+8 (mod 2^32) in the next cycle.
    - If the count after this cycle's push and pop is still < DEPTH, stay in BUSY with the new address (back-to-back fetches); otherwise go to IDLE.
  - DROP: the outstanding request belongs to a flushed path. Keep req and addr stable. On ack, discard the data (no push, no pc_w) and go to IDLE.
- Space rule: count + (1 if a request is outstanding) never exceeds DEPTH. With DEPTH=2, throughput is 1 instruction/cycle when ack is asserted every cycle and decode is always ready.
- Latency: rst deasserted at edge E0 gives imem_req=1 after E1. Data acked at edge Ek gives instr_valid=1 after Ek+1 if the FIFO was empty.
- Branch (branch_valid=1), in priority over everything except rst:
  - FIFO flushed (count=0). A same-cycle pop is ignored; a same-cycle ack data is discarded.
  - fetch_pc <= {branch_target[31:2], 2'b00}.
  - IDLE: go to IDLE; a new request starts next cycle.
  - BUSY without ack: go to DROP.
  - BUSY with ack: go to IDLE (nothing left to drop).
  - DROP: stay in DROP with the new fetch_pc.
  - No pc_w is generated by the branch itself.
- FIFO full plus instr_ready=1: the pop frees a slot, so a request may start in the same cycle.
- FIFO empty: instr_valid=0. instr and instr_pc hold their last values and are don't-care.
- pc_w is high for exactly one cycle per accepted, non-discarded fetch; otherwise 0. pc_write holds its last value.

Decomposition:
- Package fetch_pkg:
  - state enum: IDLE, BUSY, DROP.
  - WORD_BYTES=4 and PC_AHEAD=8.
  - Instruction-buffer entry struct: instr and pc.
- One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, head outputs. Flush has priority over push and pop.

Test Plan:
- Reset, ack every cycle, instr_ready=1:
  - fetches at 0x0, 0x4, 0x8.
  - pc_w pulses with pc_write 0x8, 0xC, 0x10.
  - instr_valid first rises one cycle after the first ack.
- instr_ready=0, ack always 1:
  - exactly DEPTH=2 instructions buffered (0x0, 0x4) and imem_req drops to 0.
  - raising instr_ready resumes fetching at 0x8 in the same cycle as the first pop.
- Request to 0x10 outstanding with ack=0, then branch_valid with target 0x103:
  - state goes to DROP; ack data for 0x10 is discarded with no pc_w.
  - next request is to 0x100, and instr_pc=0x100 is the next valid instruction.
- branch_valid, ack and instr_ready all in the same cycle with a full FIFO:
  - FIFO becomes empty and the acked data is discarded.
  - next cycle imem_req=1 to the target.
- RESET_VECTOR=32'hFFFF_FFF8:
  - fetches at 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - pc_write values 0x0, 0x4, 0x8.
- rst asserted while in BUSY:
  - next cycle all outputs are at reset values; the late ack is ignored.
  - after rst deasserts, fetching restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch control states (IDLE, BUSY, DROP)
//   fetch_entry_t : instruction-buffer entry (instruction word + its address)
//   WORD_BYTES    : fetch stride in bytes
//   PC_AHEAD      : architectural R15 offset from the fetch address
package fetch_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned PC_AHEAD   = 8;

    // Clears the byte-offset bits of a redirect target.
    localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory port, execute redirect,
// decode-side instruction stream and the register-bank PC write port.
//   master : the fetch unit
//   slave  : memory / execute / decode / register bank side
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        branch_valid;
    logic [31:0] branch_target;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic [31:0] pc_write;
    logic        pc_w;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_write, pc_w,
        input  imem_ack, imem_rdata, branch_valid, branch_target, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_write, pc_w,
        output imem_ack, imem_rdata, branch_valid, branch_target, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous instruction buffer.
//   clk, rst   : clock, synchronous active-high reset
//   push/data  : write an entry at the tail
//   pop        : drop the head entry
//   flush      : empty the buffer; overrides push and pop
//   head/valid : current head entry and its valid flag
//   count      : number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage and pointers; power-of-two DEPTH lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word fetch at a time
// on the req/ack memory port, buffers returned words for decode, publishes
// R15 (fetch address + 8) to the register bank and follows execute redirects.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master (imem_*, branch_*, instr_*, pc_write, pc_w)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pc_w_q, pc_w_d;
    logic [ADDR_W-1:0] pc_write_q, pc_write_d;

    logic              push;
    logic              pop;
    logic              flush;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              fifo_valid;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occ_after_pop;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .valid     (fifo_valid),
        .count     (count)
    );

    assign push_entry    = '{instr: bus.imem_rdata, pc: addr_q};
    // Occupancy once this cycle's pop is taken; the slot it frees is reusable now.
    assign occ_after_pop = OCC_W'(count) - OCC_W'(pop);

    // Next-state and datapath control; a redirect outranks everything but reset.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        pc_w_d     = 1'b0;
        pc_write_d = pc_write_q;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = fifo_valid && bus.instr_ready && !bus.branch_valid;

        if (bus.branch_valid) begin
            flush      = 1'b1;
            fetch_pc_d = bus.branch_target & WORD_MASK;
            unique case (state_q)
                IDLE:       state_d = IDLE;
                // An acked request is finished; otherwise its data must be dropped.
                BUSY, DROP: state_d = bus.imem_ack ? IDLE : DROP;
                default:    state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (occ_after_pop < DEPTH_OCC) begin
                        state_d = BUSY;
                        addr_d  = fetch_pc_q;
                    end
                end
                BUSY: begin
                    if (bus.imem_ack) begin
                        push       = 1'b1;
                        fetch_pc_d = addr_q + ADDR_W'(WORD_BYTES);
                        pc_w_d     = 1'b1;
                        pc_write_d = addr_q + ADDR_W'(PC_AHEAD);
                        // Issue back-to-back only if the new entry still leaves a slot.
                        if ((occ_after_pop + OCC_W'(1)) < DEPTH_OCC) begin
                            state_d = BUSY;
                            addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        req_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VECTOR;
            req_q      <= 1'b0;
            addr_q     <= RESET_VECTOR;
            pc_w_q     <= 1'b0;
            pc_write_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc_w_q     <= pc_w_d;
            pc_write_q <= pc_write_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = fifo_valid;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.pc_w        = pc_w_q;
    assign bus.pc_write    = pc_write_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table on a DEPTH=2,
// RESET_VECTOR=0 instance plus a wrap-around sequence on a second instance.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    fetch_unit_if if0 ();
    fetch_unit_if if1 ();

    fetch_unit #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0.master)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1.master)
    );

    // Memory model: every address returns a word derived from itself.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE3A0_5A5A;
    endfunction

    assign if0.imem_rdata = mem_word(if0.imem_addr);
    assign if1.imem_rdata = mem_word(if1.imem_addr);

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        chk_head;
        logic [31:0] pc;
        logic        pcw;
        logic [31:0] pcwrite;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic a, input logic y,
                                input logic b, input logic [31:0] t,
                                input logic q, input logic [31:0] ad,
                                input logic v, input logic ch, input logic [31:0] pc,
                                input logic w, input logic [31:0] pw);
        vec_t x;
        x.rst = r; x.ack = a; x.rdy = y; x.br = b; x.tgt = t;
        x.req = q; x.addr = ad; x.valid = v; x.chk_head = ch; x.pc = pc;
        x.pcw = w; x.pcwrite = pw;
        return x;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_dut0(input int idx, input vec_t v);
        logic [31:0] exp_instr;
        chk("imem_req",    idx, 32'(if0.imem_req),    32'(v.req));
        chk("imem_addr",   idx, if0.imem_addr,        v.addr);
        chk("instr_valid", idx, 32'(if0.instr_valid), 32'(v.valid));
        chk("pc_w",        idx, 32'(if0.pc_w),        32'(v.pcw));
        chk("pc_write",    idx, if0.pc_write,         v.pcwrite);
        if (v.chk_head) begin
            exp_instr = v.valid ? mem_word(v.pc) : 32'h0;
            chk("instr_pc", idx, if0.instr_pc, v.pc);
            chk("instr",    idx, if0.instr,    exp_instr);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.imem_ack = 1'b0; if0.instr_ready = 1'b0;
        if0.branch_valid = 1'b0; if0.branch_target = '0;
        if1.imem_ack = 1'b1; if1.instr_ready = 1'b1;
        if1.branch_valid = 1'b0; if1.branch_target = '0;

        //                rst ack rdy br  tgt          req addr          vld chk pc            pcw pc_write
        // reset
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h0,     0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h0,     0, 32'h0));
        // streaming: ack every cycle, decode always ready
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'h0,     0, 0, 32'h0,     0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'h4,     1, 1, 32'h0,     1, 32'h8));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'h8,     1, 1, 32'h4,     1, 32'hC));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'hC,     1, 1, 32'h8,     1, 32'h10));
        // decode stalled: buffer fills to DEPTH and the request stops
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h0,     0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      1, 32'h0,     0, 0, 32'h0,     0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      1, 32'h4,     1, 1, 32'h0,     1, 32'h8));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0, 32'h4,     1, 1, 32'h0,     1, 32'hC));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0, 32'h4,     1, 1, 32'h0,     0, 32'hC));
        // pop from a full buffer restarts fetch at 0x8 in the same cycle
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'h8,     1, 1, 32'h4,     0, 32'hC));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      1, 32'h8,     1, 1, 32'h4,     0, 32'hC));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'hC,     1, 1, 32'h8,     1, 32'h10));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'h10,    1, 1, 32'hC,     1, 32'h14));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,      1, 32'h10,    0, 0, 32'h0,     0, 32'h14));
        // branch while 0x10 is outstanding: its data is dropped, refetch at 0x100
        vecs.push_back(mk(0, 0, 0, 1, 32'h103,    1, 32'h10,    0, 0, 32'h0,     0, 32'h14));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      1, 32'h10,    0, 0, 32'h0,     0, 32'h14));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0, 32'h10,    0, 0, 32'h0,     0, 32'h14));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      1, 32'h100,   0, 0, 32'h0,     0, 32'h14));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      1, 32'h104,   1, 1, 32'h100,   1, 32'h108));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0, 32'h104,   1, 1, 32'h100,   1, 32'h10C));
        // branch + ack + ready with a full buffer: flushed, request follows
        vecs.push_back(mk(0, 1, 1, 1, 32'h200,    0, 32'h104,   0, 0, 32'h0,     0, 32'h10C));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,      1, 32'h200,   0, 0, 32'h0,     0, 32'h10C));
        // branch on the acking cycle in BUSY: data dropped, no DROP state
        vecs.push_back(mk(0, 1, 1, 1, 32'h300,    0, 32'h200,   0, 0, 32'h0,     0, 32'h10C));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      1, 32'h300,   0, 0, 32'h0,     0, 32'h10C));
        // reset while BUSY with a late ack
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h0,     0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      1, 32'h0,     0, 0, 32'h0,     0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      1, 32'h4,     1, 1, 32'h0,     1, 32'h8));

        for (int i = 0; i < vecs.size(); i++) begin
            rst0              = vecs[i].rst;
            if0.imem_ack      = vecs[i].ack;
            if0.instr_ready   = vecs[i].rdy;
            if0.branch_valid  = vecs[i].br;
            if0.branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk_dut0(i, vecs[i]);
        end

        // Wrap-around from RESET_VECTOR=0xFFFF_FFF8 on the second instance.
        begin
            logic [31:0] w_addr  [4];
            logic [31:0] w_pc    [4];
            logic [31:0] w_pcwr  [4];
            logic        w_valid [4];
            w_addr[0] = 32'hFFFF_FFF8; w_valid[0] = 1'b0; w_pc[0] = 32'h0;         w_pcwr[0] = 32'h0;
            w_addr[1] = 32'hFFFF_FFFC; w_valid[1] = 1'b1; w_pc[1] = 32'hFFFF_FFF8; w_pcwr[1] = 32'h0;
            w_addr[2] = 32'h0000_0000; w_valid[2] = 1'b1; w_pc[2] = 32'hFFFF_FFFC; w_pcwr[2] = 32'h4;
            w_addr[3] = 32'h0000_0004; w_valid[3] = 1'b1; w_pc[3] = 32'h0000_0000; w_pcwr[3] = 32'h8;

            rst1 = 1'b1;
            @(posedge clk);
            #1;
            chk("wrap reset imem_req",  0, 32'(if1.imem_req), 32'h0);
            chk("wrap reset imem_addr", 0, if1.imem_addr,     32'hFFFF_FFF8);
            chk("wrap reset pc_write",  0, if1.pc_write,      32'h0);
            rst1 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                chk("wrap imem_req",    k, 32'(if1.imem_req),    32'h1);
                chk("wrap imem_addr",   k, if1.imem_addr,        w_addr[k]);
                chk("wrap instr_valid", k, 32'(if1.instr_valid), 32'(w_valid[k]));
                chk("wrap pc_w",        k, 32'(if1.pc_w),        32'(w_valid[k]));
                if (w_valid[k]) begin
                    chk("wrap instr_pc", k, if1.instr_pc, w_pc[k]);
                    chk("wrap instr",    k, if1.instr,    mem_word(w_pc[k]));
                    chk("wrap pc_write", k, if1.pc_write, w_pcwr[k]);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
